// File: rtl/bcd_adder8_ctl.sv
`default_nettype none
// ============================================================================
// bcd_adder8_ctl : operand entry sequencer and two-cycle digit-serial BCD adder
// Rev 1.0 - initial release
// ============================================================================
module bcd_adder8_ctl #(
  parameter int BLINK_CYCLES = 25_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [9:0]  SW,
  input  logic        enter,
  output logic [2:0]  out_mux_sel,
  output logic [11:0] RSLT,
  output logic        rslt_valid
);

  localparam logic [2:0] c_SHOWA     = 3'd0;
  localparam logic [2:0] c_SHOWB     = 3'd1;
  localparam logic [2:0] c_SHOWCIN   = 3'd2;
  localparam logic [2:0] c_SHOWRSLT  = 3'd3;
  localparam logic [2:0] c_SHOWBLNKS = 3'd5;
  localparam logic [2:0] c_SHOWERR   = 3'd6;

  localparam int c_CNT_W = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(BLINK_CYCLES - 1);

  typedef enum logic [2:0] {
    S_A     = 3'd0,
    S_B     = 3'd1,
    S_CIN   = 3'd2,
    S_ADDLO = 3'd3,
    S_ADDHI = 3'd4,
    S_RSLT  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  state_t             r_state;
  logic [7:0]         r_a;
  logic [7:0]         r_b;
  logic               r_cin;
  logic               r_c1;
  logic               r_enter_q;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_phase;
  logic [2:0]         r_sel;
  logic               r_valid;
  logic [11:0]        r_rslt;

  logic       w_press;
  logic       w_sw_bad;
  logic [4:0] w_lo;
  logic [4:0] w_hi;
  logic       w_unused_sw;

  // One BCD digit: {carry, corrected digit}; the +6 correction wraps in 4 bits.
  function automatic logic [4:0] digit_add(input logic [3:0] x, input logic [3:0] y,
                                           input logic ci);
    logic [4:0] s;
    s = 5'(x) + 5'(y) + 5'(ci);
    if (s > 5'd9) return {1'b1, s[3:0] + 4'd6};
    else          return {1'b0, s[3:0]};
  endfunction

  assign w_press     = enter & ~r_enter_q;
  assign w_sw_bad    = (SW[7:4] > 4'd9) || (SW[3:0] > 4'd9);
  assign w_lo        = digit_add(r_a[3:0], r_b[3:0], r_cin);
  assign w_hi        = digit_add(r_a[7:4], r_b[7:4], r_c1);
  assign w_unused_sw = ^SW[9:8];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= S_A;
      r_a       <= 8'h00;
      r_b       <= 8'h00;
      r_cin     <= 1'b0;
      r_c1      <= 1'b0;
      r_enter_q <= 1'b1;
      r_cnt     <= '0;
      r_phase   <= 1'b0;
      r_sel     <= c_SHOWA;
      r_valid   <= 1'b0;
      r_rslt    <= 12'h000;
    end else begin
      r_enter_q <= enter;
      case (r_state)
        S_A: begin
          if (w_press) begin
            if (w_sw_bad) begin
              r_state <= S_ERR;
              r_sel   <= c_SHOWERR;
              r_cnt   <= '0;
              r_phase <= 1'b0;
            end else begin
              r_a     <= SW[7:0];
              r_state <= S_B;
              r_sel   <= c_SHOWB;
            end
          end
        end
        S_B: begin
          if (w_press) begin
            if (w_sw_bad) begin
              r_state <= S_ERR;
              r_sel   <= c_SHOWERR;
              r_cnt   <= '0;
              r_phase <= 1'b0;
            end else begin
              r_b     <= SW[7:0];
              r_state <= S_CIN;
              r_sel   <= c_SHOWCIN;
            end
          end
        end
        S_CIN: begin
          if (w_press) begin
            r_cin   <= SW[0];
            r_state <= S_ADDLO;
            r_sel   <= c_SHOWBLNKS;
          end
        end
        S_ADDLO: begin
          r_rslt[3:0] <= w_lo[3:0];
          r_c1        <= w_lo[4];
          r_state     <= S_ADDHI;
          r_sel       <= c_SHOWBLNKS;
        end
        S_ADDHI: begin
          r_rslt[7:4]  <= w_hi[3:0];
          r_rslt[11:8] <= {3'b000, w_hi[4]};
          r_state      <= S_RSLT;
          r_sel        <= c_SHOWRSLT;
          r_valid      <= 1'b1;
        end
        S_RSLT: begin
          if (w_press) begin
            r_state <= S_A;
            r_sel   <= c_SHOWA;
            r_valid <= 1'b0;
          end
        end
        S_ERR: begin
          if (w_press) begin
            r_state <= S_A;
            r_sel   <= c_SHOWA;
            r_cnt   <= '0;
            r_phase <= 1'b0;
          end else if (r_cnt == c_CNT_MAX) begin
            // Phase flips here, so the select follows the new phase.
            r_cnt   <= '0;
            r_phase <= ~r_phase;
            r_sel   <= r_phase ? c_SHOWERR : c_SHOWBLNKS;
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_A;
          r_sel   <= c_SHOWA;
          r_valid <= 1'b0;
          r_cnt   <= '0;
          r_phase <= 1'b0;
        end
      endcase
    end
  end

  assign out_mux_sel = r_sel;
  assign rslt_valid  = r_valid;
  assign RSLT        = r_rslt;

endmodule
`default_nettype wire

// File: tb/tb_bcd_adder8_ctl.sv
`default_nettype none
// ============================================================================
// tb_bcd_adder8_ctl : scoreboard bench for the BCD adder controller
// Rev 1.0 - initial release
// ============================================================================
module tb_bcd_adder8_ctl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  SW;
  logic        enter;
  logic [2:0]  out_mux_sel;
  logic [11:0] RSLT;
  logic        rslt_valid;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [11:0] sb_q[$];
  logic        prev_valid = 1'b0;

  bcd_adder8_ctl #(.BLINK_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .SW(SW), .enter(enter),
    .out_mux_sel(out_mux_sel), .RSLT(RSLT), .rslt_valid(rslt_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Decimal reference: convert operands to integers, add, convert back.
  function automatic logic [11:0] bcd_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic ci);
    int s;
    s = int'(a[7:4]) * 10 + int'(a[3:0]) + int'(b[7:4]) * 10 + int'(b[3:0]) + int'(ci);
    return {4'(s / 100), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  function automatic bit bcd_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [9:0] sw);
    SW = sw;
    enter = 1'b1;
    tick();
    enter = 1'b0;
    tick();
  endtask

  // From S_CIN: carry-in press, latency checks, result, return to S_A.
  task automatic finish_add(input logic [7:0] a, input logic [7:0] b, input logic ci);
    sb_q.push_back(bcd_model(a, b, ci));
    SW = {9'($urandom), ci};
    enter = 1'b1;
    tick();
    check("sel_addlo", 32'(out_mux_sel), 32'd5);
    enter = 1'b0;
    tick();
    check("sel_addhi", 32'(out_mux_sel), 32'd5);
    tick();
    check("sel_rslt", 32'(out_mux_sel), 32'd3);
    check("valid_rslt", 32'(rslt_valid), 32'd1);
    press(10'($urandom));
    check("sel_back_a", 32'(out_mux_sel), 32'd0);
    check("valid_low", 32'(rslt_valid), 32'd0);
  endtask

  task automatic do_add(input logic [7:0] a, input logic [7:0] b, input logic ci);
    press({2'($urandom), a});
    if (!bcd_ok(a)) begin
      check("err_on_a", 32'(out_mux_sel), 32'd6);
      press(10'($urandom));
      check("err_exit_a", 32'(out_mux_sel), 32'd0);
      return;
    end
    check("sel_b", 32'(out_mux_sel), 32'd1);
    press({2'($urandom), b});
    if (!bcd_ok(b)) begin
      check("err_on_b", 32'(out_mux_sel), 32'd6);
      press(10'($urandom));
      check("err_exit_b", 32'(out_mux_sel), 32'd0);
      return;
    end
    check("sel_cin", 32'(out_mux_sel), 32'd2);
    finish_add(a, b, ci);
  endtask

  function automatic logic [3:0] rand_digit();
    if ($urandom_range(0, 9) == 0) return 4'($urandom_range(0, 15));
    return 4'($urandom_range(0, 9));
  endfunction

  // Monitor: every rising rslt_valid must match the oldest expected result.
  always @(negedge clk) begin
    if (rslt_valid && !prev_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_result", 32'(RSLT), 32'hFFFF_FFFF);
      end else begin
        check("rslt", 32'(RSLT), 32'(sb_q.pop_front()));
      end
    end
    prev_valid = rslt_valid;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    enter   = 1'b1;
    SW      = 10'h000;
    repeat (3) tick();
    check("reset_sel", 32'(out_mux_sel), 32'd0);
    check("reset_rslt", 32'(RSLT), 32'h000);
    check("reset_valid", 32'(rslt_valid), 32'd0);

    reset_n = 1'b1;
    repeat (4) tick();
    check("held_thru_reset", 32'(out_mux_sel), 32'd0);
    enter = 1'b0;
    tick();

    do_add(8'h23, 8'h45, 1'b0);
    do_add(8'h99, 8'h99, 1'b1);
    do_add(8'h58, 8'h67, 1'b1);
    do_add(8'h00, 8'h00, 1'b0);

    // Invalid entry blinks ERR/blank with a 4-cycle half period.
    SW = 10'h03A;
    enter = 1'b1;
    tick();
    check("blink_0", 32'(out_mux_sel), 32'd6);
    enter = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check($sformatf("blink_%0d", i), 32'(out_mux_sel), ((i / 4) % 2 == 1) ? 32'd5 : 32'd6);
    end
    press(10'h000);
    check("blink_exit", 32'(out_mux_sel), 32'd0);

    // Button held for 10 cycles advances exactly once.
    SW = 10'h012;
    enter = 1'b1;
    repeat (10) tick();
    check("held_one_adv", 32'(out_mux_sel), 32'd1);
    enter = 1'b0;
    tick();
    check("held_release", 32'(out_mux_sel), 32'd1);
    press(10'h034);
    check("held_sel_cin", 32'(out_mux_sel), 32'd2);
    finish_add(8'h12, 8'h34, 1'b0);

    // Reset during S_ADDHI discards the partial result.
    press(10'h055);
    press(10'h066);
    SW = 10'h001;
    enter = 1'b1;
    tick();
    enter = 1'b0;
    tick();
    reset_n = 1'b0;
    tick();
    check("midadd_rst_sel", 32'(out_mux_sel), 32'd0);
    check("midadd_rst_rslt", 32'(RSLT), 32'h000);
    check("midadd_rst_valid", 32'(rslt_valid), 32'd0);
    reset_n = 1'b1;
    tick();

    // A press arriving while the add is in flight is dropped.
    press(10'h058);
    press(10'h067);
    sb_q.push_back(bcd_model(8'h58, 8'h67, 1'b1));
    SW = 10'h001;
    enter = 1'b1;
    tick();
    enter = 1'b0;
    tick();
    enter = 1'b1;
    tick();
    check("inflight_sel", 32'(out_mux_sel), 32'd3);
    repeat (3) tick();
    check("inflight_hold", 32'(out_mux_sel), 32'd3);
    check("inflight_valid", 32'(rslt_valid), 32'd1);
    enter = 1'b0;
    tick();
    press(10'h000);
    check("inflight_exit", 32'(out_mux_sel), 32'd0);

    for (int n = 0; n < 40; n++) begin
      do_add({rand_digit(), rand_digit()}, {rand_digit(), rand_digit()}, 1'($urandom));
    end

    repeat (2) tick();
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire
